// File: rtl/memory_ctrl.sv
// Single-port synchronous memory with req/ready commands, byte strobes and a
// one-deep read response slot; zero-fills itself after reset. Option: MEMCTRL_PARITY_EN.
module memory_ctrl #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [AWIDTH-1:0]   addr_i,
    input  logic [DWIDTH-1:0]   wdata_i,
    input  logic [DWIDTH/8-1:0] wstrb_i,
    output logic                ready_o,
    output logic [DWIDTH-1:0]   rdata_o,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic                perr_o
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam int unsigned NB    = DWIDTH / 8;
`ifdef MEMCTRL_PARITY_EN
    localparam int unsigned PW    = NB;
`else
    localparam int unsigned PW    = 0;
`endif
    localparam int unsigned MW    = DWIDTH + PW;
    localparam logic [AWIDTH-1:0] LAST = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   icnt_q, icnt_d;
    logic                rvalid_q, rvalid_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic                perr_q, perr_d;

    logic [MW-1:0]       mem_q [DEPTH];
    logic [MW-1:0]       rd_word;
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_addr;
    logic [DWIDTH-1:0]   mem_wdata;
    logic [NB-1:0]       mem_wstrb;
    logic                rd_perr;
    logic                ready;

    assign rd_word = mem_q[addr_i];

`ifdef MEMCTRL_PARITY_EN
    // Even parity per lane: stored bit equals XOR of the stored byte.
    always_comb begin
        rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((^rd_word[8*i +: 8]) != rd_word[DWIDTH+i]) begin
                rd_perr = 1'b1;
            end
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        icnt_d    = icnt_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        perr_d    = perr_q;
        mem_we    = 1'b0;
        mem_addr  = addr_i;
        mem_wdata = wdata_i;
        mem_wstrb = wstrb_i;
        ready     = 1'b0;
        unique case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_addr  = icnt_q;
                mem_wdata = '0;
                mem_wstrb = '1;
                icnt_d    = icnt_q + 1'b1;
                if (icnt_q == LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready = !(rvalid_q && !rready_i);
                if (rvalid_q && rready_i) begin
                    rvalid_d = 1'b0;
                end
                if (req_i && ready) begin
                    if (we_i) begin
                        mem_we = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = rd_word[DWIDTH-1:0];
                        perr_d   = rd_perr;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= INIT;
            icnt_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            perr_q   <= perr_d;
        end
    end

    // Array has no reset; a reset edge suppresses any write.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wstrb[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
`ifdef MEMCTRL_PARITY_EN
                    mem_q[mem_addr][DWIDTH+i] <= ^mem_wdata[8*i +: 8];
`endif
                end
            end
        end
    end

    assign ready_o  = ready;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`ifdef MEMCTRL_PARITY_EN
    assign perr_o   = perr_q;
`else
    assign perr_o   = 1'b0;
`endif

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl (AWIDTH=5, DWIDTH=32): directed vectors,
// expected responses queued by the driver and checked by a handshake monitor.
module tb_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic        perr;

    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    memory_ctrl #(
        .AWIDTH(5),
        .DWIDTH(32)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .ready_o (ready),
        .rdata_o (rdata),
        .rvalid_o(rvalid),
        .rready_i(rready),
        .perr_o  (perr)
    );

    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp got=%h", {perr, rdata});
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({perr, rdata} !== e) begin
                    failures++;
                    $display("FAIL rsp got perr/data=%h required=%h",
                             {perr, rdata}, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [32:0] got,
                       input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [32:0] e);
        bit ok;
        req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL cmd_timeout addr=%0d got ready=0 required=1", a);
            req = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req = 1'b0;
            if (!w) exp_q.push_back(e);
        end
    endtask

    // Call at posedge+1 with rst_n just released.
    task automatic init_len(output int cnt);
        cnt = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ready) break;
            cnt++;
        end
        idle(1);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0;
        wdata = '0; wstrb = '0; rready = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_ready",  {32'd0, ready},  33'd0);
        chk("rst_rvalid", {32'd0, rvalid}, 33'd0);
        chk("rst_rdata",  {1'b0, rdata},   33'd0);
        chk("rst_perr",   {32'd0, perr},   33'd0);

        idle(1);
        rst_n = 1'b1;
        init_len(cnt);
        chk("init_len", 33'(cnt), 33'd32);

        cmd(1'b0, 5'd0,  '0, '0, 33'h0);
        cmd(1'b0, 5'd17, '0, '0, 33'h0);
        cmd(1'b0, 5'd31, '0, '0, 33'h0);
        idle(2);

        cmd(1'b1, 5'd3, 32'h0000_00A5, 4'hF, 33'h0);
        cmd(1'b0, 5'd3, '0, '0, {1'b0, 32'h0000_00A5});
        @(negedge clk);
        chk("pulse_hi", {32'd0, rvalid}, 33'd1);
        @(negedge clk);
        chk("pulse_lo", {32'd0, rvalid}, 33'd0);
        idle(1);

        cmd(1'b1, 5'd5, 32'h1122_3344, 4'hF, 33'h0);
        cmd(1'b1, 5'd5, 32'hFFFF_FFFF, 4'b0101, 33'h0);
        cmd(1'b1, 5'd6, 32'hFFFF_FFFF, 4'b0000, 33'h0);
        cmd(1'b0, 5'd5, '0, '0, {1'b0, 32'h11FF_33FF});
        cmd(1'b0, 5'd6, '0, '0, 33'h0);
        idle(2);

        rready = 1'b0;
        cmd(1'b0, 5'd3, '0, '0, {1'b0, 32'h0000_00A5});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_ready",  {32'd0, ready},  33'd0);
            chk("hold_rvalid", {32'd0, rvalid}, 33'd1);
            chk("hold_rdata",  {1'b0, rdata},   {1'b0, 32'h0000_00A5});
        end
        idle(1);
        rready = 1'b1;
        cmd(1'b0, 5'd5, '0, '0, {1'b0, 32'h11FF_33FF});
        chk("b2b_rvalid", {32'd0, rvalid}, 33'd1);
        idle(2);

        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(10);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        init_len(cnt);
        chk("reinit_len", 33'(cnt), 33'd32);
        cmd(1'b0, 5'd3, '0, '0, 33'h0);
        idle(2);

        rready = 1'b0;
        cmd(1'b0, 5'd0, '0, '0, 33'h0);
        @(negedge clk);
        chk("pre_rst_rvalid", {32'd0, rvalid}, 33'd1);
        rst_n = 1'b0;
        idle(1);
        chk("rst_drop_rvalid", {32'd0, rvalid}, 33'd0);
        exp_q.delete();
        rst_n = 1'b1;
        rready = 1'b1;
        init_len(cnt);
        chk("rst_rvalid_init", 33'(cnt), 33'd32);

        cmd(1'b1, 5'd31, 32'hDEAD_BEEF, 4'hF, 33'h0);
        cmd(1'b0, 5'd31, '0, '0, {1'b0, 32'hDEAD_BEEF});
        cmd(1'b0, 5'd0,  '0, '0, 33'h0);
        cmd(1'b0, 5'd31, '0, '0, {1'b0, 32'hDEAD_BEEF});
        idle(2);

`ifdef MEMCTRL_PARITY_EN
        cmd(1'b1, 5'd8, 32'h0000_0007, 4'hF, 33'h0);
        dut.mem_q[8][0] = ~dut.mem_q[8][0];
        cmd(1'b0, 5'd8, '0, '0, {1'b1, 32'h0000_0006});
        cmd(1'b1, 5'd8, 32'h0000_0007, 4'hF, 33'h0);
        cmd(1'b0, 5'd8, '0, '0, {1'b0, 32'h0000_0007});
        idle(2);
`endif

        idle(3);
        chk("queue_empty", 33'(exp_q.size()), 33'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
